// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding,
// default sizing and a width helper for requester indices.
package mult_share_arbiter_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Bits needed to index n items; never less than 1 so ports stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_core.sv
// Combinational unsigned WIDTH x WIDTH multiplier; full 2*WIDTH product.
module mult_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] q_o
);

  assign q_o = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin front end for one shared multiplier: captures the winner's
// operands, registers the product and holds it until acknowledged.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int  WIDTH   = DEFAULT_WIDTH,
  parameter int  NUM_REQ = DEFAULT_NUM_REQ,
  localparam int ID_W    = clog2_min1(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [2*WIDTH-1:0]       res_q,
  input  logic                     res_ack,
  output logic                     busy,
  output state_t                   dbg_state,
  output logic [ID_W-1:0]          dbg_rr_ptr
);

  // Handshakes: grant is a one-cycle pulse meaning "operands captured";
  // res_valid stays high with res_q/res_id stable until res_ack is sampled
  // high at a clock edge; res_ack with res_valid low has no effect.

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, id_q, res_id_q, win_id, next_ptr;
  logic [WIDTH-1:0]     a_q, b_q, win_a, win_b;
  logic [NUM_REQ-1:0]   grant_q, masked_req;
  logic                 res_valid_q;
  logic [2*WIDTH-1:0]   prod_q, mult_q;
  logic                 start, load_res, done;

  mult_core #(.WIDTH(WIDTH)) u_core (
    .a_i (a_q),
    .b_i (b_q),
    .q_o (mult_q)
  );

  // Rotate-mask-priority: lowest set request at or above rr_ptr wins,
  // otherwise wrap around to the lowest set request overall.
  always_comb begin
    masked_req = '0;
    win_id     = '0;
    win_a      = '0;
    win_b      = '0;
    for (int i = 0; i < NUM_REQ; i++)
      masked_req[i] = req[i] && (ID_W'(i) >= rr_ptr_q);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) win_id = ID_W'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (masked_req[i]) win_id = ID_W'(i);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        win_a = a_in[i*WIDTH +: WIDTH];
        win_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign next_ptr = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req) state_d = ST_MULT;
      ST_MULT: state_d = ST_HOLD;
      ST_HOLD: if (res_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    start    = (state_q == ST_IDLE) && (|req);
    load_res = (state_q == ST_MULT);
    done     = (state_q == ST_HOLD) && res_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      grant_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      prod_q      <= '0;
    end else begin
      grant_q <= '0;
      if (start) begin
        a_q     <= win_a;
        b_q     <= win_b;
        id_q    <= win_id;
        grant_q <= NUM_REQ'(1) << win_id;
      end
      if (load_res) begin
        prod_q      <= mult_q;
        res_id_q    <= id_q;
        res_valid_q <= 1'b1;
      end
      if (done) begin
        res_valid_q <= 1'b0;
        rr_ptr_q    <= next_ptr;
      end
    end
  end

  assign grant      = grant_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_q      = prod_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule
